b2b_output_link_tx: RTL and testbench

//  Per-output-board store-and-forward transmit buffer, downstream of a board-to-board switching merge engine.

---
 rtl/b2b_output_link_tx_if.sv | 32 +++
 rtl/b2b_output_link_tx.sv | 229 ++++++++++++++++++++++
 tb/tb_b2b_output_link_tx.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/b2b_output_link_tx_if.sv
// Write-side and link-side signal bundle for b2b_output_link_tx.
// master: merge engine / link driver side. slave: the transmit buffer itself.
interface b2b_output_link_tx_if #(
  parameter int unsigned DATA_WIDTH = 65
) ();

  logic [DATA_WIDTH-1:0] event_data;
  logic                  event_wren;
  logic                  event_almost_full;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    output event_data,
    output event_wren,
    input  event_almost_full,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

  modport slave (
    input  event_data,
    input  event_wren,
    output event_almost_full,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

endinterface

// File: rtl/b2b_output_link_tx.sv
// Store-and-forward transmit buffer for one output board link.
// Buffers merged event words and forwards each complete event contiguously on a
// valid/ready link. Falls back to cut-through when an event fills the whole FIFO.
// Optional build macro B2B_TX_STATS_EN adds tx_event_count / tx_word_count outputs.
module b2b_output_link_tx #(
  parameter int unsigned DATA_WIDTH      = 65,
  parameter int unsigned FIFO_DEPTH_BITS = 9,
  parameter int unsigned AFULL_MARGIN    = 8,
  parameter logic [7:0]  HDR_MARKER      = 8'hAB,
  parameter logic [7:0]  FTR_MARKER      = 8'hCD,
  parameter int unsigned GAP_CYCLES      = 2
) (
  input  logic                    b2b_clk,
  input  logic                    b2b_rst_n,
  input  logic                    b2b_srst_n,
  b2b_output_link_tx_if.slave     link,
  output logic                    overflow,
  output logic                    oversize_evt,
  output logic [15:0]             drop_count
`ifdef B2B_TX_STATS_EN
  ,
  output logic [31:0]             tx_event_count,
  output logic [31:0]             tx_word_count
`endif
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int unsigned AW    = FIFO_DEPTH_BITS;
  localparam int unsigned PW    = FIFO_DEPTH_BITS + 1;
  localparam int unsigned GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [PW-1:0] DEPTH_CNT = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_THR = PW'(DEPTH - AFULL_MARGIN);
  localparam logic [GW-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StXfer = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;

  // Header and footer must be distinguishable for event framing to work.
  if (HDR_MARKER == FTR_MARKER) begin : g_marker_check
    $error("HDR_MARKER and FTR_MARKER must differ");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [PW-1:0]         fill_q, fill_d;
  logic [PW-1:0]         complete_q;
  logic                  afull_q;
  logic [1:0]            state_q, state_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
  logic                  oversize_q, oversize_d;
  logic                  overflow_q;
  logic [15:0]           drop_count_q;

  logic full, wr_en, rd_en, wr_ftr, head_ftr, ftr_out;

  assign full       = (fill_q == DEPTH_CNT);
  assign wr_en      = link.event_wren && !full;
  assign rd_en      = tx_valid_q && link.tx_ready;
  assign wr_ftr     = link.event_data[DATA_WIDTH-1] && (link.event_data[63:56] == FTR_MARKER);
  assign head_ftr   = tx_data_q[DATA_WIDTH-1] && (tx_data_q[63:56] == FTR_MARKER);
  assign ftr_out    = rd_en && head_ftr;
  assign rd_ptr_nxt = rd_ptr_q + AW'(1);

  // Fill level: the word shown on tx stays counted until the link accepts it.
  always_comb begin
    fill_d = fill_q;
    if (wr_en && !rd_en) begin
      fill_d = fill_q + PW'(1);
    end else if (!wr_en && rd_en) begin
      fill_d = fill_q - PW'(1);
    end
  end

  // Transmit FSM and registered link output.
  always_comb begin
    state_d    = state_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    gap_cnt_d  = gap_cnt_q;
    oversize_d = oversize_q;
    case (state_q)
      StIdle: begin
        if (complete_q != '0) begin
          state_d    = StXfer;
          tx_valid_d = 1'b1;
          tx_data_d  = mem[rd_ptr_q];
        end else if (full) begin
          // No footer fits: stream the partial event out to avoid deadlock.
          state_d    = StXfer;
          tx_valid_d = 1'b1;
          tx_data_d  = mem[rd_ptr_q];
          oversize_d = 1'b1;
        end
      end
      StXfer: begin
        if (tx_valid_q) begin
          if (rd_en) begin
            if (head_ftr) begin
              tx_valid_d = 1'b0;
              if (GAP_CYCLES > 0) begin
                state_d   = StGap;
                gap_cnt_d = '0;
              end else begin
                state_d = StIdle;
              end
            end else if (fill_q > PW'(1)) begin
              tx_data_d = mem[rd_ptr_nxt];
            end else if (wr_en) begin
              // Next word is being written this very cycle; bypass the array.
              tx_data_d = link.event_data;
            end else begin
              tx_valid_d = 1'b0;
            end
          end
        end else if (fill_q != '0) begin
          // Cut-through starved earlier; resume once a word is buffered.
          tx_valid_d = 1'b1;
          tx_data_d  = mem[rd_ptr_q];
        end
      end
      StGap: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge b2b_clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= link.event_data;
    end
  end

  // FIFO pointers, fill level, complete-event count and almost-full flag.
  always_ff @(posedge b2b_clk or negedge b2b_rst_n) begin
    if (!b2b_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      complete_q <= '0;
      afull_q    <= 1'b0;
    end else if (!b2b_srst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      complete_q <= '0;
      afull_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_nxt;
      fill_q  <= fill_d;
      afull_q <= (fill_d >= AFULL_THR);
      if ((wr_en && wr_ftr) && !ftr_out) begin
        complete_q <= complete_q + PW'(1);
      end else if (!(wr_en && wr_ftr) && ftr_out) begin
        complete_q <= complete_q - PW'(1);
      end
    end
  end

  // FSM state, link output register and sticky status.
  always_ff @(posedge b2b_clk or negedge b2b_rst_n) begin
    if (!b2b_rst_n) begin
      state_q      <= StIdle;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      gap_cnt_q    <= '0;
      oversize_q   <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else if (!b2b_srst_n) begin
      state_q      <= StIdle;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      gap_cnt_q    <= '0;
      oversize_q   <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q    <= state_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      gap_cnt_q  <= gap_cnt_d;
      oversize_q <= oversize_d;
      if (link.event_wren && full) begin
        overflow_q <= 1'b1;
        if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
      end
    end
  end

`ifdef B2B_TX_STATS_EN
  logic [31:0] tx_event_count_q, tx_word_count_q;

  // Link statistics; both counters wrap.
  always_ff @(posedge b2b_clk or negedge b2b_rst_n) begin
    if (!b2b_rst_n) begin
      tx_event_count_q <= '0;
      tx_word_count_q  <= '0;
    end else if (!b2b_srst_n) begin
      tx_event_count_q <= '0;
      tx_word_count_q  <= '0;
    end else begin
      if (ftr_out) tx_event_count_q <= tx_event_count_q + 32'd1;
      if (rd_en)   tx_word_count_q  <= tx_word_count_q + 32'd1;
    end
  end

  assign tx_event_count = tx_event_count_q;
  assign tx_word_count  = tx_word_count_q;
`endif

  assign link.event_almost_full = afull_q;
  assign link.tx_valid          = tx_valid_q;
  assign link.tx_data           = tx_data_q;
  assign overflow               = overflow_q;
  assign oversize_evt           = oversize_q;
  assign drop_count             = drop_count_q;

endmodule

// File: tb/tb_b2b_output_link_tx.sv
// Self-checking bench for b2b_output_link_tx (small FIFO build).
// A queue-based scoreboard tracks buffered words, fill-derived flags and drops;
// directed sections check latency, gap, handshake, cut-through and resets.
module tb_b2b_output_link_tx;

  localparam int unsigned DW        = 65;
  localparam int unsigned DB        = 4;
  localparam int unsigned AM        = 4;
  localparam int unsigned GAP       = 2;
  localparam int          DEPTH     = 16;
  localparam int          AFULL_THR = 12;
  localparam logic [7:0]  HDR       = 8'hAB;
  localparam logic [7:0]  FTR       = 8'hCD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        srst_n = 1'b1;
  logic        overflow, oversize_evt;
  logic [15:0] drop_count;
`ifdef B2B_TX_STATS_EN
  logic [31:0] tx_event_count, tx_word_count;
`endif

  b2b_output_link_tx_if #(.DATA_WIDTH(DW)) link_if ();

  b2b_output_link_tx #(
    .DATA_WIDTH      (DW),
    .FIFO_DEPTH_BITS (DB),
    .AFULL_MARGIN    (AM),
    .HDR_MARKER      (HDR),
    .FTR_MARKER      (FTR),
    .GAP_CYCLES      (GAP)
  ) dut (
    .b2b_clk        (clk),
    .b2b_rst_n      (rst_n),
    .b2b_srst_n     (srst_n),
    .link           (link_if),
    .overflow       (overflow),
    .oversize_evt   (oversize_evt),
    .drop_count     (drop_count)
`ifdef B2B_TX_STATS_EN
    ,
    .tx_event_count (tx_event_count),
    .tx_word_count  (tx_word_count)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [DW-1:0] sbq[$];
  int          acc_cyc[$];
  bit          m_afull, m_ovf, hold_pending;
  int          m_drop, m_words, m_events;
  logic [DW-1:0] prev_data;
  int          ready_mode = 0;
  bit          abort = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit is_ftr(input logic [DW-1:0] w);
    return w[DW-1] && (w[63:56] == FTR);
  endfunction

  function automatic logic [DW-1:0] mk_ctrl(input logic [7:0] mk);
    logic [63:0] r;
    r = {$urandom, $urandom};
    return {1'b1, mk, r[55:0]};
  endfunction

  // Random payload word; may be a control word, but never a footer.
  function automatic logic [DW-1:0] mk_data();
    logic [DW-1:0] w;
    w = {1'($urandom_range(0, 1)), $urandom, $urandom};
    if (is_ftr(w)) w[56] = ~w[56];
    return w;
  endfunction

  task automatic flush_model();
    sbq.delete();
    m_afull = 0; m_ovf = 0; m_drop = 0; m_words = 0; m_events = 0;
    hold_pending = 0;
  endtask

  // One clock: check outputs mid-cycle, advance the model to the edge.
  task automatic step();
    int sz0;
    logic [DW-1:0] exp_w;
    @(negedge clk);
    sz0 = sbq.size();
    check_eq("almost_full", link_if.event_almost_full, m_afull);
    check_eq("overflow", overflow, m_ovf);
    check_eq("drop_count", drop_count, m_drop);
    if (hold_pending) begin
      check_eq("hold_valid", link_if.tx_valid, 1);
      check_eq("hold_data", link_if.tx_data, prev_data);
    end
    if (!srst_n) begin
      flush_model();
    end else begin
      hold_pending = link_if.tx_valid && !link_if.tx_ready;
      prev_data    = link_if.tx_data;
      if (link_if.tx_valid && link_if.tx_ready) begin
        acc_cyc.push_back(cyc);
        check_eq("sb_nonempty", sz0 != 0, 1);
        if (sz0 != 0) begin
          exp_w = sbq.pop_front();
          check_eq("tx_data", link_if.tx_data, exp_w);
        end
        m_words++;
        if (is_ftr(link_if.tx_data)) m_events++;
      end
      if (link_if.event_wren) begin
        if (sz0 >= DEPTH) begin
          m_ovf = 1;
          if (m_drop < 65535) m_drop++;
        end else begin
          sbq.push_back(link_if.event_data);
        end
      end
      m_afull = (sbq.size() >= AFULL_THR);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (ready_mode == 1) link_if.tx_ready = ~link_if.tx_ready;
    else if (ready_mode == 2) link_if.tx_ready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic write_word(input logic [DW-1:0] w);
    link_if.event_wren = 1'b1;
    link_if.event_data = w;
    step();
    link_if.event_wren = 1'b0;
  endtask

  task automatic send_event(input int len, output int ftr_c);
    write_word(mk_ctrl(HDR));
    for (int i = 0; i < len - 2; i++) write_word(mk_data());
    ftr_c = cyc;
    write_word(mk_ctrl(FTR));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, link_if.tx_valid, 0);
    check_eq({tag, "_data"}, link_if.tx_data, 0);
    check_eq({tag, "_afull"}, link_if.event_almost_full, 0);
    check_eq({tag, "_ovf"}, overflow, 0);
    check_eq({tag, "_oversize"}, oversize_evt, 0);
    check_eq({tag, "_drop"}, drop_count, 0);
  endtask

  // Assert async reset between edges; outputs must clear immediately.
  task automatic async_reset();
    #3 rst_n = 1'b0;
    #1;
    check_all_zero("arst");
    flush_model();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int c, c1, tries;
    link_if.event_wren = 1'b0;
    link_if.event_data = '0;
    link_if.tx_ready   = 1'b0;
    flush_model();

    // Power-on reset.
    #22;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 4-word event, ready held high: header two cycles after footer write.
    link_if.tx_ready = 1'b1;
    acc_cyc.delete();
    send_event(4, c);
    idle(10);
    check_eq("a_n_acc", acc_cyc.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < acc_cyc.size()) check_eq("a_latency", acc_cyc[i], c + 2 + i);

    // Same event with ready toggling every cycle.
    acc_cyc.delete();
    ready_mode = 1;
    send_event(4, c);
    idle(14);
    ready_mode = 0;
    link_if.tx_ready = 1'b1;
    idle(4);
    check_eq("b_n_acc", acc_cyc.size(), 4);

    // Second footer written in the cycle the first footer is accepted.
    acc_cyc.delete();
    send_event(3, c1);
    idle(1);
    send_event(3, c);
    idle(12);
    check_eq("c_n_acc", acc_cyc.size(), 6);
    if (acc_cyc.size() == 6) begin
      check_eq("c_ftr1_acc", acc_cyc[2], c);
      check_eq("c_hdr2", acc_cyc[3], c + GAP + 2);
      check_eq("c_d2", acc_cyc[4], c + GAP + 3);
      check_eq("c_ftr2", acc_cyc[5], c + GAP + 4);
    end

    // Fill without a footer: almost_full, overflow, then cut-through.
    link_if.tx_ready = 1'b0;
    acc_cyc.delete();
    write_word(mk_ctrl(HDR));
    for (int i = 2; i <= 17; i++) begin
      if (i == 12) check_eq("d_afull_before", link_if.event_almost_full, 0);
      write_word(mk_data());
      if (i == 12) check_eq("d_afull_after", link_if.event_almost_full, 1);
    end
    check_eq("d_overflow", overflow, 1);
    check_eq("d_drop", drop_count, 1);
    check_eq("d_oversize", oversize_evt, 1);
    check_eq("d_valid", link_if.tx_valid, 1);
    link_if.tx_ready = 1'b1;
    idle(20);
    check_eq("e_starved_valid", link_if.tx_valid, 0);
    check_eq("e_drained", sbq.size(), 0);
    check_eq("e_n_acc16", acc_cyc.size(), 16);
    for (int k = 0; k < 4; k++) begin
      write_word((k == 3) ? mk_ctrl(FTR) : mk_data());
      idle(2);
    end
    idle(10);
    check_eq("e_n_acc20", acc_cyc.size(), 20);
    check_eq("e_oversize_sticky", oversize_evt, 1);
    check_eq("e_end_valid", link_if.tx_valid, 0);

    // Async reset mid-transfer, then a normal event.
    link_if.tx_ready = 1'b0;
    send_event(5, c);
    idle(3);
    check_eq("f_valid_before", link_if.tx_valid, 1);
    async_reset();
    link_if.tx_ready = 1'b1;
    acc_cyc.delete();
    send_event(4, c);
    idle(10);
    check_eq("f_n_acc", acc_cyc.size(), 4);
    if (acc_cyc.size() > 0) check_eq("f_latency", acc_cyc[0], c + 2);

    // Sync reset mid-transfer: effective only at the next edge.
    link_if.tx_ready = 1'b0;
    send_event(5, c);
    idle(3);
    check_eq("g_valid_before", link_if.tx_valid, 1);
    srst_n = 1'b0;
    #1;
    check_eq("g_srst_not_yet", link_if.tx_valid, 1);
    step();
    srst_n = 1'b1;
    check_all_zero("srst");
    link_if.tx_ready = 1'b1;
    acc_cyc.delete();
    send_event(4, c);
    idle(10);
    check_eq("g_n_acc", acc_cyc.size(), 4);
    if (acc_cyc.size() > 0) check_eq("g_latency", acc_cyc[0], c + 2);

    // Randomized traffic with a backpressure-respecting writer.
    ready_mode = 2;
    for (int e = 0; e < 40 && !abort; e++) begin
      int len;
      len = $urandom_range(2, 11);
      for (int i = 0; i < len && !abort; i++) begin
        logic [DW-1:0] w;
        bit done;
        w = (i == 0) ? mk_ctrl(HDR) : (i == len - 1) ? mk_ctrl(FTR) : mk_data();
        done = 0;
        tries = 0;
        while (!done && !abort) begin
          if (($urandom_range(0, 3) != 0) && !link_if.event_almost_full) begin
            write_word(w);
            done = 1;
          end else begin
            step();
          end
          tries++;
          if (!done && tries > 300) begin
            check_eq("h_write_timeout", 1, 0);
            abort = 1;
          end
        end
      end
    end
    ready_mode = 0;
    link_if.tx_ready = 1'b1;
    tries = 0;
    while ((sbq.size() != 0 || link_if.tx_valid) && tries < 600) begin
      step();
      tries++;
    end
    check_eq("h_drained", sbq.size(), 0);
    check_eq("h_overflow", overflow, 0);

`ifdef B2B_TX_STATS_EN
    async_reset();
    link_if.tx_ready = 1'b1;
    for (int e = 0; e < 3; e++) send_event(5, c);
    idle(20);
    check_eq("stats_events", tx_event_count, 3);
    check_eq("stats_words", tx_word_count, 15);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
